// File: rtl/nibble_sub_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
// Optional flags (zero, overflow) are enabled by NIBBLE_SUB_FLAGS_EN.
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_sub.sv
// Combinational 4-bit subtract slice with borrow chain in/out.
// Reused once per cycle by the serial subtractor top.
module nibble_sub
    import nibble_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                borrow_in,
    output logic [NIBBLE_W-1:0] diff,
    output logic                borrow_out
);

    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b}
                              - {{NIBBLE_W{1'b0}}, borrow_in};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial a - b - borrow_in, one nibble per clock, LSB first.
// Define NIBBLE_SUB_FLAGS_EN to add registered zero/overflow outputs.
module nibble_serial_subtractor
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef NIBBLE_SUB_FLAGS_EN
    output logic             zero,
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int N     = nibble_count(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef NIBBLE_SUB_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    logic [IDX_W+1:0]    sh;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
    logic                nib_bo;
    logic [WIDTH-1:0]    diff_upd;

    // Nibble offset in bits is index * 4
    assign sh    = {idx_q, 2'b00};
    assign nib_a = NIBBLE_W'(a_q >> sh);
    assign nib_b = NIBBLE_W'(b_q >> sh);

    nibble_sub u_slice (
        .a          (nib_a),
        .b          (nib_b),
        .borrow_in  (borrow_q),
        .diff       (nib_d),
        .borrow_out (nib_bo)
    );

    assign diff_upd = (diff_q & ~(WIDTH'(4'hF) << sh))
                    | (WIDTH'(nib_d) << sh);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef NIBBLE_SUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = borrow_in;
                    idx_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                diff_d   = diff_upd;
                borrow_d = nib_bo;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    bout_d  = nib_bo;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef NIBBLE_SUB_FLAGS_EN
                    zero_d  = (diff_upd == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                           && (nib_d[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef NIBBLE_SUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef NIBBLE_SUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef NIBBLE_SUB_FLAGS_EN
    assign zero       = zero_q;
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomised and directed bench for nibble_serial_subtractor.
// Instances at WIDTH 16, 8 and 4 share clock and reset.
module tb_nibble_serial_subtractor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        s16 = 0, bi16 = 0, busy16, done16, bo16;
    logic [15:0] a16 = 0, b16 = 0, d16;
    logic        s8 = 0, bi8 = 0, busy8, done8, bo8;
    logic [7:0]  a8 = 0, b8 = 0, d8;
    logic        s4 = 0, bi4 = 0, busy4, done4, bo4;
    logic [3:0]  a4 = 0, b4 = 0, d4;
`ifdef NIBBLE_SUB_FLAGS_EN
    logic z16, v16, z8, v8, z4, v4;
`endif

    int tests = 0;
    int fails = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(s16),
        .a(a16), .b(b16), .borrow_in(bi16),
        .busy(busy16), .done(done16), .diff(d16),
`ifdef NIBBLE_SUB_FLAGS_EN
        .zero(z16), .overflow(v16),
`endif
        .borrow_out(bo16)
    );

    nibble_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8),
        .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(d8),
`ifdef NIBBLE_SUB_FLAGS_EN
        .zero(z8), .overflow(v8),
`endif
        .borrow_out(bo8)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(s4),
        .a(a4), .b(b4), .borrow_in(bi4),
        .busy(busy4), .done(done4), .diff(d4),
`ifdef NIBBLE_SUB_FLAGS_EN
        .zero(z4), .overflow(v4),
`endif
        .borrow_out(bo4)
    );

    // Drive one start pulse; returns at the negedge after the capture edge
    task automatic issue16(input logic [15:0] av, input logic [15:0] bv,
                           input logic bv_i);
        @(negedge clk);
        s16 = 1; a16 = av; b16 = bv; bi16 = bv_i;
        @(negedge clk);
        s16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
    endtask

    task automatic wait16(output int lat, output int busy_n, output bit ok);
        lat = 0; busy_n = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done16) begin
                ok = 1;
                break;
            end
            if (busy16) busy_n++;
            @(negedge clk);
            lat++;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout16: done not seen within %0d cycles", lat);
        end
    endtask

    task automatic check16(input string nm, input logic [15:0] av,
                           input logic [15:0] bv, input logic bv_i);
        logic [16:0] r;
        r = {1'b0, av} - {1'b0, bv} - {16'd0, bv_i};
        tests++;
        if (d16 !== r[15:0] || bo16 !== r[16]) begin
            fails++;
            $display("FAIL %s: diff=%h bo=%b expected diff=%h bo=%b",
                     nm, d16, bo16, r[15:0], r[16]);
        end
`ifdef NIBBLE_SUB_FLAGS_EN
        begin
            int  s;
            logic ez, ev;
            s  = int'($signed(av)) - int'($signed(bv)) - int'(bv_i);
            ev = (s < -32768) || (s > 32767);
            ez = (r[15:0] == 16'd0);
            tests++;
            if (z16 !== ez || v16 !== ev) begin
                fails++;
                $display("FAIL %s_flags: zero=%b ovf=%b expected zero=%b ovf=%b",
                         nm, z16, v16, ez, ev);
            end
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy16, done16, d16, bo16, busy8, done8, d8, bo8,
             busy4, done4, d4, bo4} !== '0) begin
            fails++;
            $display("FAIL reset: outputs not zero (16: b%b d%b %h %b)",
                     busy16, done16, d16, bo16);
        end
`ifdef NIBBLE_SUB_FLAGS_EN
        tests++;
        if ({z16, v16, z8, v8, z4, v4} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: flags=%b expected 0",
                     {z16, v16, z8, v8, z4, v4});
        end
`endif
        reset_n = 1;
    endtask

    task automatic test_directed();
        int lat, bn;
        bit ok;
        logic [15:0] ta [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555};
        logic [15:0] tb [4] = '{16'h0034, 16'h0001, 16'h0000, 16'h5555};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue16(ta[i], tb[i], tc[i]);
            wait16(lat, bn, ok);
            tests++;
            if (lat != 4 || bn != 4) begin
                fails++;
                $display("FAIL latency%0d: lat=%0d busy=%0d expected 4/4",
                         i, lat, bn);
            end
            tests++;
            if (busy16 !== 1'b0) begin
                fails++;
                $display("FAIL busy_in_done%0d: busy=%b expected 0", i, busy16);
            end
            check16($sformatf("directed%0d", i), ta[i], tb[i], tc[i]);
            @(negedge clk);
            tests++;
            if (done16 !== 1'b0 || busy16 !== 1'b0) begin
                fails++;
                $display("FAIL done_pulse%0d: done=%b busy=%b expected 0/0",
                         i, done16, busy16);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        bit ok;
        issue16(16'hA5C3, 16'h1F2E, 1'b1);
        @(negedge clk);
        s16 = 1; a16 = 16'h0000; b16 = 16'hFFFF; bi16 = 0;
        @(negedge clk);
        s16 = 0;
        wait16(lat, bn, ok);
        tests++;
        if (lat != 2) begin
            fails++;
            $display("FAIL ignored_start_lat: lat=%0d expected 2", lat);
        end
        check16("ignored_start", 16'hA5C3, 16'h1F2E, 1'b1);
        s16 = 1; a16 = 16'h0F00; b16 = 16'h1000; bi16 = 0;
        @(negedge clk);
        s16 = 0; a16 = '1; b16 = '1;
        tests++;
        if (busy16 !== 1'b1 || done16 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1/0",
                     busy16, done16);
        end
        wait16(lat, bn, ok);
        tests++;
        if (lat + 1 != 5) begin
            fails++;
            $display("FAIL b2b_spacing: %0d cycles expected 5", lat + 1);
        end
        check16("b2b_second", 16'h0F00, 16'h1000, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bn;
        bit ok;
        bit seen;
        issue16(16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        tests++;
        if ({busy16, done16, d16, bo16} !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b diff=%h bo=%b expected 0",
                     busy16, done16, d16, bo16);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16) seen = 1;
        end
        reset_n = 1;
        repeat (3) begin
            @(negedge clk);
            if (done16 || busy16) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_no_done: done/busy seen=%b expected 0", seen);
        end
        issue16(16'h4321, 16'h1234, 1'b1);
        wait16(lat, bn, ok);
        check16("after_reset", 16'h4321, 16'h1234, 1'b1);
    endtask

    task automatic test_random16(input int n);
        int lat, bn;
        bit ok;
        logic [15:0] av, bv;
        logic bvi;
        for (int i = 0; i < n; i++) begin
            av = 16'($urandom); bv = 16'($urandom); bvi = 1'($urandom);
            if (i % 8 == 0) bv = av;
            issue16(av, bv, bvi);
            wait16(lat, bn, ok);
            if (!ok) break;
            check16("random16", av, bv, bvi);
        end
    endtask

    task automatic test_random8(input int n);
        int k;
        logic [8:0] r;
        logic [7:0] av, bv;
        logic bvi;
        for (int i = 0; i < n; i++) begin
            av = 8'($urandom); bv = 8'($urandom); bvi = 1'($urandom);
            @(negedge clk);
            s8 = 1; a8 = av; b8 = bv; bi8 = bvi;
            @(negedge clk);
            s8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
            k = 0;
            while (!done8 && k < 20) begin
                @(negedge clk);
                k++;
            end
            r = {1'b0, av} - {1'b0, bv} - {8'd0, bvi};
            tests++;
            if (k != 2 || d8 !== r[7:0] || bo8 !== r[8]) begin
                fails++;
                $display("FAIL random8: lat=%0d diff=%h bo=%b expected 2 %h %b",
                         k, d8, bo8, r[7:0], r[8]);
            end
        end
    endtask

    task automatic test_random4(input int n);
        int k;
        logic [4:0] r;
        logic [3:0] av, bv;
        logic bvi;
        for (int i = 0; i < n; i++) begin
            av = 4'($urandom); bv = 4'($urandom); bvi = 1'($urandom);
            @(negedge clk);
            s4 = 1; a4 = av; b4 = bv; bi4 = bvi;
            @(negedge clk);
            s4 = 0; a4 = 4'($urandom); b4 = 4'($urandom);
            k = 0;
            while (!done4 && k < 20) begin
                @(negedge clk);
                k++;
            end
            r = {1'b0, av} - {1'b0, bv} - {4'd0, bvi};
            tests++;
            if (k != 1 || d4 !== r[3:0] || bo4 !== r[4]) begin
                fails++;
                $display("FAIL random4: lat=%0d diff=%h bo=%b expected 1 %h %b",
                         k, d4, bo4, r[3:0], r[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_random16(400);
        test_random8(300);
        test_random4(300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
